// File: rtl/sbox_pkg.sv
// Shared definitions for the 1-to-N buffered switch box: FSM state
// encodings and the default data width / FIFO depth.
package sbox_pkg;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } sbox_state_t;

endpackage

// File: rtl/sbox_fifo.sv
// Synchronous FIFO used as the per-channel output buffer of the switch box.
// Registered storage with no bypass; head reads back zero while empty.
module sbox_fifo
    import sbox_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [SIZE-1:0] push_data,
    output logic [SIZE-1:0] head,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count
);

    logic [SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because head is gated by empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sbox1xn_buf.sv
// Parametrised 1-to-N buffered switch box. One wr/full input stream is routed
// to the active channel's FIFO; a select change waits until that FIFO drains.
module sbox1xn_buf
    import sbox_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int N     = 2,
    parameter int SELW  = 1,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SIZE-1:0]   in1_data,
    input  logic              in1_wr,
    output logic              in1_full,
    input  logic [SELW-1:0]   sel,
    output logic [N*SIZE-1:0] out_data,
    output logic [N-1:0]      out_wr,
    input  logic [N-1:0]      out_full,
    output logic [SELW-1:0]   sel_active,
    output logic              switching
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [SELW:0] N_SEL = N[SELW:0];

    sbox_state_t     state;
    sbox_state_t     state_next;
    logic [SELW-1:0] target;
    logic [SELW-1:0] target_next;
    logic [SELW-1:0] sel_active_next;

    logic [N-1:0]    fifo_empty;
    logic [N-1:0]    fifo_full;
    logic [N-1:0]    push;
    logic [CW-1:0]   fifo_count [N];

    logic            accept;
    logic            sel_valid;
    logic            active_full;
    logic            active_drained;

    assign accept    = in1_wr && !in1_full;
    assign sel_valid = ({1'b0, sel} < N_SEL);

    // Pick out the flags of the channel currently being fed.
    always_comb begin
        active_full    = 1'b0;
        active_drained = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_active == SELW'(k)) begin
                active_full    = fifo_full[k];
                active_drained = (fifo_count[k] == '0);
            end
        end
    end

    // State, latched target and active channel registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            target     <= '0;
            sel_active <= '0;
        end else begin
            state      <= state_next;
            target     <= target_next;
            sel_active <= sel_active_next;
        end
    end

    // Next-state logic: RUN watches sel, DRAIN waits for the old channel to
    // empty, SWITCH commits the latched target in a single cycle.
    always_comb begin
        state_next      = state;
        target_next     = target;
        sel_active_next = sel_active;
        in1_full        = 1'b1;
        switching       = 1'b1;
        case (state)
            RUN: begin
                in1_full  = active_full;
                switching = 1'b0;
                if ((sel != sel_active) && sel_valid) begin
                    target_next = sel;
                    state_next  = DRAIN;
                end
            end
            DRAIN: begin
                if (active_drained) state_next = SWITCH;
            end
            SWITCH: begin
                sel_active_next = target;
                state_next      = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign push[k]   = accept && (sel_active == SELW'(k));
        assign out_wr[k] = !fifo_empty[k] && !out_full[k];

        sbox_fifo #(
            .SIZE  (SIZE),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[k]),
            .pop       (out_wr[k]),
            .push_data (in1_data),
            .head      (out_data[k*SIZE +: SIZE]),
            .empty     (fifo_empty[k]),
            .full      (fifo_full[k]),
            .count     (fifo_count[k])
        );
    end

endmodule

// File: tb/tb_sbox1xn_buf.sv
// Self-checking bench for sbox1xn_buf with four channels: a per-channel
// scoreboard tracks every accepted token, a vector table covers routing and
// backpressure, and scripted sequences cover switching and reset corners.
module tb_sbox1xn_buf;

    localparam int SIZE  = 32;
    localparam int N     = 4;
    localparam int SELW  = 3;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [SIZE-1:0]   in1_data;
    logic              in1_wr;
    logic              in1_full;
    logic [SELW-1:0]   sel;
    logic [N*SIZE-1:0] out_data;
    logic [N-1:0]      out_wr;
    logic [N-1:0]      out_full;
    logic [SELW-1:0]   sel_active;
    logic              switching;

    sbox1xn_buf #(
        .SIZE  (SIZE),
        .N     (N),
        .SELW  (SELW),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in1_data   (in1_data),
        .in1_wr     (in1_wr),
        .in1_full   (in1_full),
        .sel        (sel),
        .out_data   (out_data),
        .out_wr     (out_wr),
        .out_full   (out_full),
        .sel_active (sel_active),
        .switching  (switching)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    typedef struct {
        logic [SELW-1:0] sel;
        logic            wr;
        logic [SIZE-1:0] data;
        logic [N-1:0]    ofull;
        int              chan;
        logic            efull;
        logic            esw;
        logic [SELW-1:0] eact;
    } vec_t;

    vec_t            tbl [22];
    logic [SIZE-1:0] sb [N][$];
    int              checks = 0;
    int              passes = 0;
    int              exp_chan = 0;
    bit              chk_en = 1'b0;
    logic            exp_full;
    logic            exp_sw;
    logic [SELW-1:0] exp_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_output();
        logic [SIZE-1:0] exp_data;
        logic            exp_wr;
        for (int k = 0; k < N; k++) begin
            exp_wr   = (sb[k].size() != 0) && !out_full[k];
            exp_data = (sb[k].size() != 0) ? sb[k][0] : '0;
            check($sformatf("out_wr[%0d]", k), 32'(out_wr[k]), 32'(exp_wr));
            check($sformatf("out_data[%0d]", k), out_data[k*SIZE +: SIZE], exp_data);
            if (out_wr[k] && sb[k].size() != 0) void'(sb[k].pop_front());
        end
        if (chk_en) begin
            check("in1_full", 32'(in1_full), 32'(exp_full));
            check("switching", 32'(switching), 32'(exp_sw));
            check("sel_active", 32'(sel_active), 32'(exp_act));
        end
        if (in1_wr && !in1_full) sb[exp_chan].push_back(in1_data);
    endtask

    task automatic tick();
        @(negedge clock);
        if (!reset) check_output();
        @(posedge clock);
        if (reset) begin
            for (int k = 0; k < N; k++) sb[k].delete();
        end
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        sel      = v.sel;
        in1_wr   = v.wr;
        in1_data = v.data;
        out_full = v.ofull;
        exp_chan = v.chan;
        exp_full = v.efull;
        exp_sw   = v.esw;
        exp_act  = v.eact;
        chk_en   = 1'b1;
        tick();
    endtask

    task automatic step(input logic [SELW-1:0] s, input logic w, input logic [SIZE-1:0] d,
                        input logic [N-1:0] of, input int ch, input logic ef, input logic es,
                        input logic [SELW-1:0] ea);
        vec_t v;
        v = '{s, w, d, of, ch, ef, es, ea};
        apply_stimulus(v);
    endtask

    initial begin
        // sel, wr, data, out_full, chan, in1_full, switching, sel_active
        tbl[0]  = '{3'd2, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{3'd2, 1'b0, 32'h0,  4'b0000, 0, 1'b1, 1'b1, 3'd0};
        tbl[2]  = '{3'd2, 1'b0, 32'h0,  4'b0000, 0, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{3'd2, 1'b1, 32'hA1, 4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[4]  = '{3'd2, 1'b1, 32'hA2, 4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[5]  = '{3'd2, 1'b1, 32'hA3, 4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[6]  = '{3'd7, 1'b0, 32'h0,  4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[7]  = '{3'd7, 1'b0, 32'h0,  4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[8]  = '{3'd0, 1'b0, 32'h0,  4'b0000, 2, 1'b0, 1'b0, 3'd2};
        tbl[9]  = '{3'd0, 1'b0, 32'h0,  4'b0000, 2, 1'b1, 1'b1, 3'd2};
        tbl[10] = '{3'd0, 1'b0, 32'h0,  4'b0000, 2, 1'b1, 1'b1, 3'd2};
        tbl[11] = '{3'd0, 1'b1, 32'hD1, 4'b0001, 0, 1'b0, 1'b0, 3'd0};
        tbl[12] = '{3'd0, 1'b1, 32'hD2, 4'b0001, 0, 1'b0, 1'b0, 3'd0};
        tbl[13] = '{3'd0, 1'b1, 32'hD3, 4'b0001, 0, 1'b0, 1'b0, 3'd0};
        tbl[14] = '{3'd0, 1'b1, 32'hD4, 4'b0001, 0, 1'b0, 1'b0, 3'd0};
        tbl[15] = '{3'd0, 1'b1, 32'hD5, 4'b0001, 0, 1'b1, 1'b0, 3'd0};
        tbl[16] = '{3'd0, 1'b1, 32'hD5, 4'b0000, 0, 1'b1, 1'b0, 3'd0};
        tbl[17] = '{3'd0, 1'b1, 32'hD5, 4'b0000, 0, 1'b0, 1'b0, 3'd0};
        tbl[18] = '{3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0};
        tbl[19] = '{3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0};
        tbl[20] = '{3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0};
        tbl[21] = '{3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0};

        reset    = 1'b1;
        in1_wr   = 1'b0;
        in1_data = '0;
        sel      = '0;
        out_full = '0;
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] routing, invalid select and backpressure vectors");
        for (int i = 0; i < 22; i++) apply_stimulus(tbl[i]);

        $display("[TB] safe switch from channel 1 to channel 3");
        step(3'd1, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0);
        step(3'd1, 1'b0, 32'h0,  4'b0000, 0, 1'b1, 1'b1, 3'd0);
        step(3'd1, 1'b0, 32'h0,  4'b0000, 0, 1'b1, 1'b1, 3'd0);
        step(3'd1, 1'b1, 32'hB1, 4'b0010, 1, 1'b0, 1'b0, 3'd1);
        step(3'd1, 1'b1, 32'hB2, 4'b0010, 1, 1'b0, 1'b0, 3'd1);
        step(3'd1, 1'b1, 32'hB3, 4'b0010, 1, 1'b0, 1'b0, 3'd1);
        step(3'd3, 1'b0, 32'h0,  4'b0010, 1, 1'b0, 1'b0, 3'd1);
        step(3'd3, 1'b1, 32'hC0, 4'b0010, 1, 1'b1, 1'b1, 3'd1);
        step(3'd3, 1'b0, 32'h0,  4'b0010, 1, 1'b1, 1'b1, 3'd1);
        step(3'd3, 1'b0, 32'h0,  4'b0010, 1, 1'b1, 1'b1, 3'd1);
        for (int i = 0; i < 5; i++) step(3'd3, 1'b0, 32'h0, 4'b0000, 1, 1'b1, 1'b1, 3'd1);
        step(3'd3, 1'b1, 32'hE1, 4'b0000, 3, 1'b0, 1'b0, 3'd3);
        step(3'd3, 1'b0, 32'h0,  4'b0000, 3, 1'b0, 1'b0, 3'd3);

        $display("[TB] select glitching during drain");
        step(3'd0, 1'b0, 32'h0,  4'b0000, 3, 1'b0, 1'b0, 3'd3);
        step(3'd0, 1'b0, 32'h0,  4'b0000, 3, 1'b1, 1'b1, 3'd3);
        step(3'd0, 1'b0, 32'h0,  4'b0000, 3, 1'b1, 1'b1, 3'd3);
        step(3'd0, 1'b1, 32'hF1, 4'b0001, 0, 1'b0, 1'b0, 3'd0);
        step(3'd0, 1'b1, 32'hF2, 4'b0001, 0, 1'b0, 1'b0, 3'd0);
        step(3'd1, 1'b0, 32'h0,  4'b0001, 0, 1'b0, 1'b0, 3'd0);
        step(3'd2, 1'b0, 32'h0,  4'b0001, 0, 1'b1, 1'b1, 3'd0);
        step(3'd2, 1'b0, 32'h0,  4'b0001, 0, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) step(3'd2, 1'b0, 32'h0, 4'b0000, 0, 1'b1, 1'b1, 3'd0);
        step(3'd2, 1'b0, 32'h0,  4'b0000, 1, 1'b0, 1'b0, 3'd1);
        step(3'd2, 1'b0, 32'h0,  4'b0000, 1, 1'b1, 1'b1, 3'd1);
        step(3'd2, 1'b0, 32'h0,  4'b0000, 1, 1'b1, 1'b1, 3'd1);
        step(3'd2, 1'b0, 32'h0,  4'b0000, 2, 1'b0, 1'b0, 3'd2);

        $display("[TB] simultaneous push and pop at count 3");
        step(3'd2, 1'b1, 32'h90, 4'b0100, 2, 1'b0, 1'b0, 3'd2);
        step(3'd2, 1'b1, 32'h91, 4'b0100, 2, 1'b0, 1'b0, 3'd2);
        step(3'd2, 1'b1, 32'h92, 4'b0100, 2, 1'b0, 1'b0, 3'd2);
        for (int i = 0; i < 16; i++) begin
            step(3'd2, 1'b1, 32'hC000_0000 + 32'(i), 4'b0000, 2, 1'b0, 1'b0, 3'd2);
            check("pushpop_count", 32'(sb[2].size()), 32'd3);
        end
        for (int i = 0; i < 4; i++) step(3'd2, 1'b0, 32'h0, 4'b0000, 2, 1'b0, 1'b0, 3'd2);

        $display("[TB] reset in the middle of a drain");
        step(3'd2, 1'b1, 32'h70, 4'b0100, 2, 1'b0, 1'b0, 3'd2);
        step(3'd2, 1'b1, 32'h71, 4'b0100, 2, 1'b0, 1'b0, 3'd2);
        step(3'd0, 1'b0, 32'h0,  4'b0100, 2, 1'b0, 1'b0, 3'd2);
        step(3'd0, 1'b0, 32'h0,  4'b0100, 2, 1'b1, 1'b1, 3'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step(3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0);
        step(3'd0, 1'b1, 32'h5A, 4'b0000, 0, 1'b0, 1'b0, 3'd0);
        step(3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0);
        step(3'd0, 1'b0, 32'h0,  4'b0000, 0, 1'b0, 1'b0, 3'd0);

        for (int k = 0; k < N; k++) check($sformatf("leftover[%0d]", k), 32'(sb[k].size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sbox1xn_buf.md
Name: sbox1xn_buf

Overview:
- Parametrised 1-to-N switch box for Multi-Dataflow Composer reconfigurable datapaths; next generation of the 1x2 combinational sbox.
- Routes one wr/full input stream to one of N output channels, each with its own FIFO of DEPTH entries.
- Reconfiguration is safe: a change of the select input takes effect only after the currently active channel's FIFO has drained, so no token is lost or misrouted mid-stream.

Parameters:
- SIZE, 32, data width in bits.
- N, 2, number of output channels (N >= 2).
- SELW, 1, select width; must satisfy 2**SELW >= N.
- DEPTH, 4, entries per output FIFO; power of two, DEPTH >= 2.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in1_data  in  SIZE  input token.
- in1_wr  in  1  input write strobe.
- in1_full  out  1  backpressure to producer; a write is accepted only when in1_wr=1 and in1_full=0.
- sel  in  SELW  requested output channel.
- out_data  out  N*SIZE  channel k occupies bits [k*SIZE +: SIZE].
- out_wr  out  N  per-channel write strobe to the consumer.
- out_full  in  N  per-channel consumer backpressure.
- sel_active  out  SELW  channel currently being fed.
- switching  out  1  high while a reconfiguration is pending (DRAIN or SWITCH state).

Behaviour:
- Reset values:
  - all FIFOs empty; out_wr=0; out_data=0.
  - sel_active=0; target=0; state=RUN.
  - switching=0; in1_full = 0, the full flag of FIFO 0.
- Input accept: on an accepted write in RUN state, in1_data is pushed into FIFO[sel_active]. Only that FIFO is written.
- Output, per channel k:
  - out_wr[k] = !empty[k] && !out_full[k], combinational.
  - out_data slice k = head of FIFO[k] when non-empty, else 0.
  - Each out_wr[k]=1 cycle pops one entry.
- Latency: a token written in cycle t can appear on out_wr at t+1 at the earliest (the FIFO is registered, with no bypass).
- FIFO rules:
  - full when count==DEPTH; in1_full is driven from that flag, so a write into a full FIFO cannot occur.
  - A push and a pop in the same cycle are both performed and count is unchanged; this also holds when count==DEPTH-1 or count==1.
  - Pointers wrap modulo DEPTH.
- State machine, states RUN / DRAIN / SWITCH:
  - RUN: in1_full = full[sel_active].
    - If sel != sel_active and sel < N: latch target <= sel and go to DRAIN. The input is blocked from the next cycle on; a write in the transition cycle is still accepted into the old channel.
    - If sel >= N: the value is ignored and the block stays in RUN.
  - DRAIN: in1_full=1 and switching=1.
    - When empty[sel_active]=1 (including a pop that empties it this cycle, as seen on the next cycle's flag), go to SWITCH.
    - Other channels keep draining independently.
  - SWITCH: one cycle; in1_full=1 and switching=1; sel_active <= target; next state RUN.
  - sel changes during DRAIN or SWITCH are ignored. In RUN, sel is re-evaluated every cycle, so the last stable value wins.
  - If sel returns to its old value during DRAIN, the switch still completes to the latched target, then switches back through a second drain.
- Non-selected channels with remaining data keep emitting; FIFOs are never flushed except by reset.
- Reset mid-operation: reset has priority over all activity. All FIFO contents are discarded and every output returns to its reset value in the following cycle.

Decomposition:
- Shared package/header sbox_pkg: the state encodings RUN=2'd0, DRAIN=2'd1, SWITCH=2'd2, plus the default SIZE/DEPTH constants.
- One sub-module, sbox_fifo (SIZE, DEPTH):
  - synchronous FIFO with push, pop, head data, empty, full and count;
  - same clock and reset as the parent;
  - instantiated N times through a generate loop.
- The FSM, write demux and output gating live in the top module.

Test Plan:
- Basic routing. Setup: reset, N=4, sel=2, out_full=0. Stimulus: write 0xA1, 0xA2, 0xA3 back to back. Required response:
  - out_wr[2] pulses on cycles t+1..t+3 with data A1, A2, A3;
  - out_wr[0], [1] and [3] stay 0, and their data slices stay 0.
- Backpressure / full. Setup: sel=0, out_full[0]=1. Stimulus: write 5 tokens with DEPTH=4. Required response:
  - in1_full rises after the 4th accept and the 5th is held;
  - releasing out_full[0] drains 1..4 in order, then the 5th is accepted.
- Safe switch. Setup: FIFO[1] holds 3 tokens and out_full[1]=1. Stimulus: sel changes from 1 to 3. Required response:
  - switching=1 and in1_full=1 while FIFO[1] is non-empty;
  - release out_full[1]: 3 pops, then SWITCH, then sel_active=3 and in1_full=0;
  - the next write appears only on channel 3.
- Invalid and glitching select. Stimulus and required response:
  - sel=7 with N=4: no state change;
  - sel 0→1→2 during DRAIN: the switch lands on 1, then a second drain and switch lands on 2.
- Simultaneous push and pop. Stimulus: at count=3, write every cycle while out_full=0. Required response: count stays 3, in1_full stays 0, data order is preserved, and 16 consecutive tokens are lossless across pointer wrap.
- Reset mid-stream. Stimulus: assert reset with 2 FIFOs non-empty and state=DRAIN. Required response: the next cycle has out_wr=0, out_data=0, sel_active=0, switching=0 and in1_full=0.
